truth_table_sweeper: RTL and testbench

- Sequencer that drives every input combination of an N-input combinational function block and captures its 1-bit output into a truth-table register.
- Hardware equivalent of the team's counter-driven exhaustive benches, now synthesizable and start/done handshaked.
- Sits between a control source (bench or top-level FSM) and one combinational function under evaluation.
- Reports the captured table, the count of true minterms, and constant-0/constant-1 flags (detects tautologies such as a full sum-of-minterms function).

---
 rtl/sweep_pkg.sv | 23 ++
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/sweep_settle_timer.sv | 34 +++
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper and related sampling controllers.
package sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCapture,
    StFinish
  } state_e;

  function automatic int unsigned depth_of(input int unsigned n);
    return 32'd1 << n;
  endfunction

  // Minterm count reaches 2**n inclusive, so it needs one bit more than the input vector.
  function automatic int unsigned popcount_width(input int unsigned n);
    return n + 32'd1;
  endfunction

  localparam int unsigned N_IN_DEFAULT = 3;
  localparam int unsigned DEPTH = depth_of(N_IN_DEFAULT);

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between a sweep requester (master) and the sweeper (slave).
interface truth_table_sweeper_if
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN = 3
);
  logic                        start;
  logic                        abort;
  logic                        busy;
  logic                        done;
  logic [depth_of(N_IN)-1:0]   table_out;
  logic [popcount_width(N_IN)-1:0] ones_count;
  logic                        is_const0;
  logic                        is_const1;

  modport master (
    output start, abort,
    input  busy, done, table_out, ones_count, is_const0, is_const1
  );

  modport slave (
    input  start, abort,
    output busy, done, table_out, ones_count, is_const0, is_const1
  );
endinterface

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that stops at zero; zero flags that the held vector has settled.
module sweep_settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N_IN-input function, captures its output into a truth table
// and reports minterm count plus constant-0/constant-1 flags.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.slave   ctl,
  output logic [N_IN-1:0]        fn_in,
  input  logic                   fn_out
);

  localparam int unsigned Depth = depth_of(N_IN);
  localparam int unsigned Cw    = popcount_width(N_IN);
  localparam int unsigned Tw    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] fn_q, fn_d;
  logic [Depth-1:0] tbl_q, tbl_d;
  logic [Cw-1:0]   ones_q, ones_d;
  logic            c0_q, c0_d, c1_q, c1_d, done_q, done_d;
  logic            tmr_load, tmr_en, tmr_zero;

  sweep_settle_timer #(
    .W(Tw)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (Tw'(SETTLE_CYCLES - 1)),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fn_d     = fn_q;
    tbl_d    = tbl_q;
    ones_d   = ones_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctl.start) begin
          tbl_d    = '0;
          ones_d   = '0;
          c0_d     = 1'b0;
          c1_d     = 1'b0;
          idx_d    = '0;
          fn_d     = '0;
          tmr_load = 1'b1;
          state_d  = StApply;
        end
      end
      StApply: begin
        if (ctl.abort) begin
          fn_d    = '0;
          state_d = StIdle;
        end else if (tmr_zero) begin
          state_d = StCapture;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StCapture: begin
        // Abort beats the sample: the current vector is never written.
        if (ctl.abort) begin
          fn_d    = '0;
          state_d = StIdle;
        end else begin
          tbl_d[idx_q[N_IN-1:0]] = fn_out;
          ones_d = ones_q + Cw'(fn_out);
          if (idx_q == (N_IN + 1)'(Depth - 1)) begin
            state_d = StFinish;
          end else begin
            idx_d    = idx_q + 1'b1;
            fn_d     = idx_d[N_IN-1:0];
            tmr_load = 1'b1;
            state_d  = StApply;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        c0_d    = (ones_q == '0);
        c1_d    = (ones_q == Cw'(Depth));
        fn_d    = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      fn_q    <= '0;
      tbl_q   <= '0;
      ones_q  <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fn_q    <= fn_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      done_q  <= done_d;
    end
  end

  assign fn_in          = fn_q;
  assign ctl.busy       = (state_q == StApply) || (state_q == StCapture);
  assign ctl.done       = done_q;
  assign ctl.table_out  = tbl_q;
  assign ctl.ones_count = ones_q;
  assign ctl.is_const0  = c0_q;
  assign ctl.is_const1  = c1_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 1 and 3) against a sweep-timeline model.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  int sel_v [2] = '{0, 0};
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) if0 ();
  truth_table_sweeper_if #(.N_IN(3)) if1 ();

  logic [2:0] fn_in0, fn_in1;
  logic fn_out0, fn_out1;

  // Gate-level style functions under evaluation, as a real netlist would present them.
  function automatic logic fn_dut(input int sel, input logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    case (sel)
      0: return (~a & ~b & ~c) | (~a & ~b & c) | (~a & b & ~c) | (~a & b & c) |
                (a & ~b & ~c) | (a & ~b & c) | (a & b & ~c) | (a & b & c);
      1: return a & b & c;
      2: return 1'b0;
      default: return a ^ b ^ c;
    endcase
  endfunction

  assign fn_out0 = fn_dut(sel_v[0], fn_in0);
  assign fn_out1 = fn_dut(sel_v[1], fn_in1);
  assign if0.start = start_v[0];
  assign if0.abort = abort_v[0];
  assign if1.start = start_v[1];
  assign if1.abort = abort_v[1];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0), .fn_in(fn_in0), .fn_out(fn_out0)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ctl(if1), .fn_in(fn_in1), .fn_out(fn_out1)
  );

  logic [1:0] busy_w, done_w, c0_w, c1_w;
  logic [2:0] fnin_w [2];
  logic [7:0] tbl_w [2];
  logic [3:0] ones_w [2];
  assign busy_w = {if1.busy, if0.busy};
  assign done_w = {if1.done, if0.done};
  assign c0_w = {if1.is_const0, if0.is_const0};
  assign c1_w = {if1.is_const1, if0.is_const1};
  assign fnin_w[0] = fn_in0;
  assign fnin_w[1] = fn_in1;
  assign tbl_w[0] = if0.table_out;
  assign tbl_w[1] = if1.table_out;
  assign ones_w[0] = if0.ones_count;
  assign ones_w[1] = if1.ones_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference truth: function value for minterm k, stated directly.
  function automatic logic fn_ref(input int sel, input int k);
    case (sel)
      0: return 1'b1;
      1: return (k == 7);
      2: return 1'b0;
      default: return ($countones(k[2:0]) % 2) == 1;
    endcase
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model: d = clock edges since the start edge; each vector spans settle+1 edges.
  bit m_act [2];
  int m_d [2];
  logic [7:0] m_truth [2];
  logic [7:0] m_tbl [2];
  int m_ones [2];
  bit m_c0 [2], m_c1 [2], m_done [2];

  task automatic step(input int i);
    int s, l, n;
    s = settle_of(i);
    l = 8 * (s + 1);
    m_done[i] = 1'b0;
    if (!rst_n) begin
      m_act[i] = 1'b0; m_tbl[i] = '0; m_ones[i] = 0; m_c0[i] = 1'b0; m_c1[i] = 1'b0;
    end else if (!m_act[i]) begin
      if (start_v[i]) begin
        m_act[i] = 1'b1; m_d[i] = 0; m_c0[i] = 1'b0; m_c1[i] = 1'b0;
        for (int k = 0; k < 8; k++) m_truth[i][k] = fn_ref(sel_v[i], k);
      end
    end else if (abort_v[i] && m_d[i] < l) begin
      m_act[i] = 1'b0;
    end else begin
      m_d[i]++;
      if (m_d[i] == l + 1) begin
        m_act[i] = 1'b0; m_done[i] = 1'b1;
        m_c0[i] = (m_ones[i] == 0); m_c1[i] = (m_ones[i] == 8);
      end
    end
    if (m_act[i]) begin
      n = m_d[i] / (s + 1);
      if (n > 8) n = 8;
      m_tbl[i] = '0;
      for (int k = 0; k < n; k++) m_tbl[i][k] = m_truth[i][k];
      m_ones[i] = $countones(m_tbl[i]);
    end
  endtask

  task automatic compare(input int i);
    int s, l;
    logic busy_e;
    logic [2:0] fn_e;
    s = settle_of(i);
    l = 8 * (s + 1);
    busy_e = m_act[i] && (m_d[i] < l);
    fn_e = !m_act[i] ? 3'd0 : (m_d[i] < l) ? 3'(m_d[i] / (s + 1)) : 3'd7;
    chk($sformatf("u%0d.busy", i), busy_w[i], busy_e);
    chk($sformatf("u%0d.done", i), done_w[i], m_done[i]);
    chk($sformatf("u%0d.fn_in", i), fnin_w[i], fn_e);
    chk($sformatf("u%0d.table_out", i), tbl_w[i], m_tbl[i]);
    chk($sformatf("u%0d.ones_count", i), ones_w[i], m_ones[i]);
    chk($sformatf("u%0d.is_const0", i), c0_w[i], m_c0[i]);
    chk($sformatf("u%0d.is_const1", i), c1_w[i], m_c1[i]);
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      step(i);
      compare(i);
    end
  end

  task automatic start_sweep(input int i, input int sel, output int t0);
    sel_v[i] = sel;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int i, input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done_w[i]) begin
        lat = cyc - t0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fn(input int i, input logic [2:0] v);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (fnin_w[i] == v) ok = 1'b1;
      else @(negedge clk);
    end
    chk("wait_fn_in_reached", 32'(ok), 32'd1);
  endtask

  task automatic results(input string nm, input int i, input logic [7:0] t, input int o,
                         input logic z, input logic f);
    chk({nm, ".table"}, tbl_w[i], t);
    chk({nm, ".ones"}, ones_w[i], o);
    chk({nm, ".const0"}, c0_w[i], z);
    chk({nm, ".const1"}, c1_w[i], f);
  endtask

  initial begin
    int t0, lat, dones;
    repeat (2) @(negedge clk);
    chk("reset.busy", busy_w, 2'b00);
    chk("reset.done", done_w, 2'b00);
    chk("reset.table", tbl_w[0], 8'h00);
    chk("reset.fn_in", fnin_w[0], 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_sweep(0, 0, t0);
    wait_done(0, t0, lat);
    chk("taut.latency", lat, 17);
    results("taut", 0, 8'hFF, 8, 1'b0, 1'b1);

    start_sweep(0, 1, t0);
    wait_done(0, t0, lat);
    chk("and3.latency", lat, 17);
    results("and3", 0, 8'h80, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    results("and3_persist", 0, 8'h80, 1, 1'b0, 1'b0);

    start_sweep(0, 2, t0);
    wait_done(0, t0, lat);
    results("const0", 0, 8'h00, 0, 1'b1, 1'b0);

    // Second start mid-sweep must be ignored.
    start_sweep(0, 1, t0);
    repeat (4) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, t0, lat);
    chk("restart_ignored.latency", lat, 17);
    results("restart_ignored", 0, 8'h80, 1, 1'b0, 1'b0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(done_w[0]);
    end
    chk("restart_ignored.extra_done", dones, 0);

    // Start held through FINISH: new sweep starts on the idle edge after done.
    sel_v[0] = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done(0, t0, lat);
    chk("held_start.latency1", lat, 17);
    @(negedge clk);
    t0 = cyc;
    start_v[0] = 1'b0;
    chk("held_start.busy_again", busy_w[0], 1'b1);
    wait_done(0, t0, lat);
    chk("held_start.latency2", lat, 17);

    // Abort at vector 4.
    start_sweep(0, 0, t0);
    wait_fn(0, 3'd4);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort.busy", busy_w[0], 1'b0);
    results("abort", 0, 8'h0F, 4, 1'b0, 1'b0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(done_w[0]);
    end
    chk("abort.no_done", dones, 0);

    // Reset at vector 5, then a clean sweep.
    start_sweep(0, 0, t0);
    wait_fn(0, 3'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset.busy", busy_w[0], 1'b0);
    chk("midreset.fn_in", fnin_w[0], 3'd0);
    results("midreset", 0, 8'h00, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    start_sweep(0, 1, t0);
    wait_done(0, t0, lat);
    chk("post_reset.latency", lat, 17);
    results("post_reset", 0, 8'h80, 1, 1'b0, 1'b0);

    // Reset beats a simultaneous start.
    @(negedge clk);
    rst_n = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start_v[0] = 1'b0;
    chk("reset_wins.busy", busy_w[0], 1'b0);
    @(negedge clk);
    chk("reset_wins.busy_after", busy_w[0], 1'b0);

    // XOR3 with four cycles per vector.
    start_sweep(1, 3, t0);
    repeat (4) @(negedge clk);
    chk("xor3.fn_in_step", fnin_w[1], 3'd1);
    wait_done(1, t0, lat);
    chk("xor3.latency", lat, 33);
    results("xor3", 1, 8'h96, 4, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
